pattern_scan_cpu: RTL and testbench
===================================

// Module: pattern_scan_cpu
// PURPOSE
//  CPU-register-mapped wildcard pattern scanner; successor to the fixed 16-position combinational matcher wrapper.
//  CPU loads a STR_WORDS x 64b string buffer, an up-to-8-byte pattern, a per-byte wildcard mask and a pattern length.
//  A start command launches a sequential scan, one byte position per clock.
//  The block counts matches and records the first and last match positions; results are read back over the same 64b bus.
// PARAMETERS
//  STR_WORDS  4   64b words in string buffer; N = 8*STR_WORDS bytes, 1..64
//  CNT_W      16  width of match counter and position registers
// PORTS
//  clk        in   1   clock
//  rst        in   1   synchronous, active-high reset
//  cpu_din    in   64  write data
//  cpu_ain    in   64  word address; only [7:0] decoded
//  cpu_wren   in   1   1 = write cycle; 0 = read cycle
//  cpu_dout   out  64  registered read data
//  scan_done  out  1   one-cycle pulse when a scan completes or is aborted
// BEHAVIOUR
//  Register map, cpu_ain[7:0]:
//   0x00+k  string word k, k < STR_WORDS (RW); byte j of word k = bits[8j+7:8j] = string byte 8k+j
//   0x40    pattern (RW); pattern byte i = bits[8i+7:8i]
//   0x41    cfg (RW): [7:0] wildcard, bit i=1 -> pattern byte i is don't-care; [19:16] len L (0 or >8 -> 8)
//   0x42    W: bit0 start, bit1 abort. R: {61'b0, busy, done, found}
//   0x43    R: match count        0x44 R: first match pos        0x45 R: last match pos
//   Unmapped reads return 0; unmapped writes are ignored.
//  Reads: on every cycle with cpu_wren=0, cpu_dout <= reg[cpu_ain] at the next edge (1-cycle latency); cpu_dout holds during write cycles.
//  Match at position p: for every i < L, wildcard[i]=1 or string[p+i]==pattern[i]. Positions 0..N-L, P = N-L+1.
//  FSM:
//   IDLE --start--> SCAN: on the start edge clear count; set first=last={CNT_W{1}} (none); clear done/found; p=0.
//   SCAN: evaluate p each cycle; on match count++ (saturating at 2^CNT_W-1), first set only if none, last=p, found=1.
//   SCAN: after p=P-1 -> IDLE; done=1; scan_done pulses on that same edge.
//  Timing: start written at edge t -> busy=1 after t; position p is evaluated in cycle t+1+p; busy=0 and done=1 after edge t+P.
//  Abort in SCAN: -> IDLE at next edge, done=1, scan_done pulses; count/first/last keep partial values.
//  Start+abort in the same write: abort wins. Start while busy: ignored. Abort while IDLE: ignored.
//  String/pattern/cfg writes while busy are ignored (buffer is frozen during a scan); reads are allowed at any time.
//  done is sticky until the next start or reset.
//  Reset (including mid-scan): FSM=IDLE; all buffers/cfg/count = 0; first=last={CNT_W{1}}; busy=done=found=0; cpu_dout=0; scan_done=0.
// TESTING
//  T1 STR_WORDS=4, string "abcabcab...", pattern "abc", L=3, wc=0, start -> done after 31 cycles; count=10, first=0, last=27.
//  T2 pattern "a?c", wc=0x02, string with "axc" at byte 5 and elsewhere 0 -> count=1, first=last=5, found=1.
//  T3 No match: string=0, pattern 0x41, L=1 -> count=0, first=last=0xFFFF, found=0, done=1, single scan_done pulse.
//  T4 Start, abort at cycle 3 -> scan_done 1 cycle after abort; busy=0; partial count kept; a 2nd start during a scan is ignored.
//  T5 L=0 treated as 8; wc=0xFF -> every position matches: count=25 (N=32), last=24; write to 0x00 mid-scan has no effect.
//  T6 rst asserted mid-scan -> next cycle all status/result regs at reset values; read of 0x43 returns 0 one cycle later.

Source files
------------

// File: rtl/pattern_scan_cpu.sv
// pattern_scan_cpu
//   CPU-register-mapped wildcard pattern scanner. The CPU loads a string buffer
//   (STR_WORDS x 64b), an up-to-8-byte pattern, a per-byte wildcard mask and a
//   pattern length, then starts a sequential scan that evaluates one byte
//   position per clock, counting matches and recording first/last match
//   positions.
// Ports
//   clk        clock
//   rst        synchronous, active-high reset
//   cpu_din    64b write data
//   cpu_ain    64b word address, only [7:0] decoded
//   cpu_wren   1 = write cycle, 0 = read cycle
//   cpu_dout   registered read data (1-cycle latency, holds during writes)
//   scan_done  one-cycle pulse when a scan completes or is aborted
module pattern_scan_cpu #(
  parameter int unsigned STR_WORDS = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] cpu_din,
  input  logic [63:0] cpu_ain,
  input  logic        cpu_wren,
  output logic [63:0] cpu_dout,
  output logic        scan_done
);

  localparam int unsigned N  = 8 * STR_WORDS;
  localparam int unsigned PW = $clog2(N + 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state_q;
  logic [63:0]      str_q [STR_WORDS];
  logic [63:0]      pat_q;
  logic [7:0]       wc_q;
  logic [3:0]       len_q;
  logic [CNT_W-1:0] cnt_q, first_q, last_q;
  logic             done_q, found_q, scan_done_q;
  logic [PW-1:0]    pos_q;
  logic [63:0]      dout_q;

  logic [7:0]       addr;
  logic             busy, wr_start, wr_abort, hit;
  logic [3:0]       eff_len;
  logic [PW-1:0]    last_pos;
  logic [N*8+63:0]  ext, shifted;
  logic [63:0]      window, rdata;
  logic             unused_addr_bits;

  assign addr             = cpu_ain[7:0];
  assign unused_addr_bits = ^cpu_ain[63:8];
  assign busy             = (state_q == SCAN);
  // abort wins over start when both bits are set in one write
  assign wr_abort = cpu_wren && (addr == 8'h42) && cpu_din[1];
  assign wr_start = cpu_wren && (addr == 8'h42) && cpu_din[0] && !cpu_din[1];
  assign eff_len  = (len_q == 4'd0 || len_q > 4'd8) ? 4'd8 : len_q;
  assign last_pos = PW'(N) - PW'(eff_len);

  // 8-byte window starting at the current position; zero bytes pad past the
  // end of the buffer, which only ever fall under positions i >= eff_len.
  always_comb begin
    ext = '0;
    for (int unsigned k = 0; k < STR_WORDS; k++) ext[k*64 +: 64] = str_q[k];
    shifted = ext >> {pos_q, 3'b000};
    window  = shifted[63:0];
  end

  always_comb begin
    hit = 1'b1;
    for (int unsigned i = 0; i < 8; i++) begin
      if (4'(i) < eff_len && !wc_q[i] && window[i*8 +: 8] != pat_q[i*8 +: 8])
        hit = 1'b0;
    end
  end

  always_comb begin
    rdata = '0;
    for (int unsigned k = 0; k < STR_WORDS; k++)
      if (addr == 8'(k)) rdata = str_q[k];
    case (addr)
      8'h40:   rdata = pat_q;
      8'h41:   rdata = {44'b0, len_q, 8'b0, wc_q};
      8'h42:   rdata = {61'b0, busy, done_q, found_q};
      8'h43:   rdata = 64'(cnt_q);
      8'h44:   rdata = 64'(first_q);
      8'h45:   rdata = 64'(last_q);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      for (int unsigned k = 0; k < STR_WORDS; k++) str_q[k] <= '0;
      pat_q       <= '0;
      wc_q        <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      first_q     <= '1;
      last_q      <= '1;
      done_q      <= 1'b0;
      found_q     <= 1'b0;
      scan_done_q <= 1'b0;
      pos_q       <= '0;
      dout_q      <= '0;
    end else begin
      scan_done_q <= 1'b0;
      if (!cpu_wren) dout_q <= rdata;

      // buffers are frozen while scanning
      if (cpu_wren && !busy) begin
        for (int unsigned k = 0; k < STR_WORDS; k++)
          if (addr == 8'(k)) str_q[k] <= cpu_din;
        if (addr == 8'h40) pat_q <= cpu_din;
        if (addr == 8'h41) begin
          wc_q  <= cpu_din[7:0];
          len_q <= cpu_din[19:16];
        end
      end

      case (state_q)
        IDLE: begin
          if (wr_start) begin
            state_q <= SCAN;
            cnt_q   <= '0;
            first_q <= '1;
            last_q  <= '1;
            done_q  <= 1'b0;
            found_q <= 1'b0;
            pos_q   <= '0;
          end
        end
        SCAN: begin
          if (wr_abort) begin
            state_q     <= IDLE;
            done_q      <= 1'b1;
            scan_done_q <= 1'b1;
          end else begin
            if (hit) begin
              if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
              if (!found_q) first_q <= CNT_W'(pos_q);
              last_q  <= CNT_W'(pos_q);
              found_q <= 1'b1;
            end
            if (pos_q == last_pos) begin
              state_q     <= IDLE;
              done_q      <= 1'b1;
              scan_done_q <= 1'b1;
            end else begin
              pos_q <= pos_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cpu_dout  = dout_q;
  assign scan_done = scan_done_q;

endmodule

// File: tb/tb_pattern_scan_cpu.sv
module tb_pattern_scan_cpu;

  localparam int unsigned STR_WORDS = 4;
  localparam int unsigned N         = 8 * STR_WORDS;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] cpu_din, cpu_ain, cpu_dout;
  logic        cpu_wren, scan_done;

  int errors = 0;
  int checks = 0;
  int pulses = 0;

  pattern_scan_cpu #(.STR_WORDS(STR_WORDS), .CNT_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .cpu_din  (cpu_din),
    .cpu_ain  (cpu_ain),
    .cpu_wren (cpu_wren),
    .cpu_dout (cpu_dout),
    .scan_done(scan_done)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (scan_done === 1'b1) pulses++;

  // reference state: plain byte arrays
  logic [7:0] m_str [N];
  logic [7:0] m_pat [8];
  logic [7:0] m_wc;
  logic [3:0] m_len;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [63:0] d);
    cpu_wren = 1'b1; cpu_ain = 64'(a); cpu_din = d;
    @(posedge clk); #1;
    cpu_wren = 1'b0; cpu_ain = 64'hFF; cpu_din = '0;
  endtask

  task automatic cpu_read(input logic [7:0] a, output logic [63:0] d);
    cpu_wren = 1'b0; cpu_ain = 64'(a);
    @(posedge clk); #1;
    d = cpu_dout;
    cpu_ain = 64'hFF;
  endtask

  function automatic int eff_l();
    return (m_len == 0 || m_len > 8) ? 8 : int'(m_len);
  endfunction

  function automatic logic [63:0] str_word(input int k);
    logic [63:0] w = '0;
    for (int j = 0; j < 8; j++) w[8*j +: 8] = m_str[8*k + j];
    return w;
  endfunction

  // count matches over the first npos positions, straight from the match rule
  task automatic model_scan(input int npos, output int cnt, output int first, output int last);
    int l = eff_l();
    cnt = 0; first = -1; last = -1;
    for (int p = 0; p < npos; p++) begin
      bit ok = 1'b1;
      for (int i = 0; i < l; i++)
        if (!m_wc[i] && m_str[p+i] != m_pat[i]) ok = 1'b0;
      if (ok) begin
        cnt++;
        if (first < 0) first = p;
        last = p;
      end
    end
  endtask

  task automatic load_all(input logic [63:0] cfg_word);
    logic [63:0] pw = '0;
    for (int k = 0; k < int'(STR_WORDS); k++) cpu_write(8'(k), str_word(k));
    for (int i = 0; i < 8; i++) pw[8*i +: 8] = m_pat[i];
    cpu_write(8'h40, pw);
    m_wc  = cfg_word[7:0];
    m_len = cfg_word[19:16];
    cpu_write(8'h41, cfg_word);
  endtask

  task automatic check_results(input string tag, input int npos, input logic busy_e);
    int cnt, first, last;
    logic [63:0] d;
    model_scan(npos, cnt, first, last);
    cpu_read(8'h42, d);
    check_eq({tag, " status"}, d, {61'b0, busy_e, 1'b1, cnt > 0});
    cpu_read(8'h43, d);
    check_eq({tag, " count"}, d, 64'(cnt));
    cpu_read(8'h44, d);
    check_eq({tag, " first"}, d, first < 0 ? 64'hFFFF : 64'(first));
    cpu_read(8'h45, d);
    check_eq({tag, " last"}, d, last < 0 ? 64'hFFFF : 64'(last));
  endtask

  task automatic run_scan(input string tag, input bit mid_write);
    int npos = N - eff_l() + 1;
    int polls = 0;
    int pre = pulses;
    logic [63:0] d = '0;
    cpu_write(8'h42, 64'h1);
    if (mid_write) begin
      cpu_write(8'h00, {$urandom, $urandom});
      polls = 1;
    end
    do begin
      cpu_read(8'h42, d);
      polls++;
    end while (!d[1] && polls < 300);
    check_eq({tag, " latency"}, 64'(polls), 64'(npos + 1));
    check_results(tag, npos, 1'b0);
    check_eq({tag, " pulses"}, 64'(pulses - pre), 64'd1);
    if (mid_write) begin
      cpu_read(8'h00, d);
      check_eq({tag, " frozen word0"}, d, str_word(0));
    end
  endtask

  initial begin
    logic [63:0] d;
    int pre;
    string abc = "abc";

    rst = 1'b1; cpu_wren = 1'b0; cpu_ain = 64'hFF; cpu_din = '0;
    foreach (m_str[i]) m_str[i] = 8'h00;
    foreach (m_pat[i]) m_pat[i] = 8'h00;
    m_wc = '0; m_len = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset dout", cpu_dout, 64'h0);
    check_eq("reset scan_done", 64'(scan_done), 64'h0);
    rst = 1'b0;
    cpu_read(8'h42, d); check_eq("reset status", d, 64'h0);
    cpu_read(8'h44, d); check_eq("reset first", d, 64'hFFFF);
    cpu_read(8'h45, d); check_eq("reset last", d, 64'hFFFF);
    cpu_read(8'h41, d); check_eq("reset cfg", d, 64'h0);
    cpu_read(8'h50, d); check_eq("unmapped read", d, 64'h0);

    // T1: repeating "abc", pattern "abc", L=3
    for (int i = 0; i < int'(N); i++) m_str[i] = abc[i % 3];
    for (int i = 0; i < 8; i++) m_pat[i] = (i < 3) ? abc[i] : 8'h00;
    load_all(64'h0003_0000);
    cpu_read(8'h41, d); check_eq("cfg readback", d, 64'h0003_0000);
    run_scan("T1", 1'b0);

    // T2: "a?c" with single occurrence at byte 5
    foreach (m_str[i]) m_str[i] = 8'h00;
    m_str[5] = "a"; m_str[6] = "x"; m_str[7] = "c";
    load_all(64'h0003_0002);
    run_scan("T2", 1'b0);

    // T3: no match
    foreach (m_str[i]) m_str[i] = 8'h00;
    m_pat[0] = 8'h41;
    load_all(64'h0001_0000);
    run_scan("T3", 1'b0);

    // abort while idle is ignored, done stays sticky
    pre = pulses;
    cpu_write(8'h42, 64'h2);
    cpu_read(8'h42, d); check_eq("idle abort status", d, 64'h2);
    check_eq("idle abort pulses", 64'(pulses - pre), 64'd0);
    // start+abort together: abort wins, no scan starts
    cpu_write(8'h42, 64'h3);
    cpu_read(8'h42, d); check_eq("start+abort status", d, 64'h2);

    // T5: L=0 -> 8, all wildcards; mid-scan string write ignored
    for (int i = 0; i < int'(N); i++) m_str[i] = 8'($urandom);
    load_all(64'h0000_00FF);
    run_scan("T5", 1'b1);

    // T4: abort after 3 evaluated positions; a second start is ignored
    for (int i = 0; i < int'(N); i++) m_str[i] = abc[i % 3];
    for (int i = 0; i < 8; i++) m_pat[i] = (i < 3) ? abc[i] : 8'h00;
    load_all(64'h0003_0000);
    pre = pulses;
    cpu_write(8'h42, 64'h1);
    cpu_write(8'h42, 64'h1);
    cpu_read(8'hFF, d);
    cpu_read(8'hFF, d);
    cpu_write(8'h42, 64'h2);
    check_eq("T4 abort pulse", 64'(scan_done), 64'h1);
    check_results("T4", 3, 1'b0);
    check_eq("T4 pulses", 64'(pulses - pre), 64'd1);

    // randomized scans
    for (int t = 0; t < 12; t++) begin
      logic [63:0] cfg;
      for (int i = 0; i < int'(N); i++) m_str[i] = ($urandom_range(0, 2) == 0) ? 8'h62 : 8'h61;
      for (int i = 0; i < 8; i++) m_pat[i] = ($urandom_range(0, 2) == 0) ? 8'h62 : 8'h61;
      cfg = {$urandom, $urandom};
      cfg[7:0] = 8'($urandom & $urandom & $urandom);
      load_all(cfg);
      cpu_read(8'h41, d);
      check_eq($sformatf("R%0d cfg", t), d, cfg & 64'h000F_00FF);
      run_scan($sformatf("R%0d", t), t[0]);
    end

    // T6: reset mid-scan
    pre = pulses;
    cpu_write(8'h42, 64'h1);
    cpu_read(8'hFF, d);
    cpu_read(8'hFF, d);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("T6 dout", cpu_dout, 64'h0);
    check_eq("T6 scan_done", 64'(scan_done), 64'h0);
    cpu_read(8'h42, d); check_eq("T6 status", d, 64'h0);
    cpu_read(8'h43, d); check_eq("T6 count", d, 64'h0);
    cpu_read(8'h44, d); check_eq("T6 first", d, 64'hFFFF);
    cpu_read(8'h45, d); check_eq("T6 last", d, 64'hFFFF);
    cpu_read(8'h00, d); check_eq("T6 word0", d, 64'h0);
    cpu_read(8'h40, d); check_eq("T6 pattern", d, 64'h0);
    check_eq("T6 pulses", 64'(pulses - pre), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
